// File: rtl/sfetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches and buffers the
// returned instructions so that decode sees {valid, pc, instr}.
module sfetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_pipeline,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned SumW = PtrW + 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
  localparam logic [SumW-1:0] DepthP  = SumW'(FIFO_DEPTH);
  localparam logic [CntW:0]   DepthC  = (CntW + 1)'(FIFO_DEPTH);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d, nfill_q, nfill_d, drop_q, drop_d;
  logic [DATA_WIDTH-1:0] pc_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] pc_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_d [FIFO_DEPTH];

  logic            req_ok, head_ok, accept, pop, fill;
  logic [CntW-1:0] unfilled;
  logic [CntW:0]   occupancy;
  logic [SumW-1:0] fill_sum;
  logic [PtrW-1:0] fill_idx;

  // Entries fill in order, so filled ones are the nfill oldest; the next fill slot
  // sits nfill entries past the head.
  always_comb begin
    fill_sum  = {1'b0, head_q} + SumW'(nfill_q);
    fill_idx  = (fill_sum >= DepthP) ? PtrW'(fill_sum - DepthP) : PtrW'(fill_sum);
    unfilled  = count_q - nfill_q;
    occupancy = {1'b0, count_q} + {1'b0, drop_q};
    req_ok    = !redirect_valid && (occupancy < DepthC);
    head_ok   = (nfill_q != '0);
    accept    = imem_req_valid && imem_req_ready;
    pop       = head_ok && !stall_pipeline && !redirect_valid;
    fill      = imem_resp_valid && (drop_q == '0);
  end

  always_comb begin
    imem_req_valid = !rst && req_ok;
    imem_req_addr  = fetch_pc_q;
    if_valid       = !rst && head_ok;
    if_pc          = if_valid ? pc_q[head_q] : '0;
    if_instr       = if_valid ? instr_q[head_q] : '0;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    nfill_d    = nfill_q;
    drop_d     = drop_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    if (redirect_valid) begin
      // Every unfilled entry still owes a response; a response arriving now pays one off.
      fetch_pc_d = redirect_pc & ~DATA_WIDTH'(3);
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      nfill_d    = '0;
      drop_d     = drop_q + unfilled - CntW'(imem_resp_valid);
    end else begin
      if (imem_resp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CntW'(1);
        end else begin
          instr_d[fill_idx] = imem_resp_data;
        end
      end
      if (accept) begin
        pc_d[tail_q] = fetch_pc_q;
        tail_d       = ptr_inc(tail_q);
        fetch_pc_d   = fetch_pc_q + DATA_WIDTH'(4);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      count_d = count_q + CntW'(accept) - CntW'(pop);
      nfill_d = nfill_q + CntW'(fill) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      nfill_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      nfill_q    <= nfill_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    instr_q <= instr_d;
  end

`ifndef SYNTHESIS
  a_resp_owed: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (drop_q != '0 || unfilled != '0));
  a_count_max: assert property (@(posedge clk) disable iff (rst)
    {1'b0, count_q} <= DepthC);
`endif

endmodule
